serial_adder: RTL

Parametrised multi-cycle add/subtract unit. Successor to the single-bit full adder.
- Processes two WIDTH-bit operands DIGIT bits per clock through a registered carry chain.
- Trades latency for area.
- Sits between switch/register inputs and LED/display outputs.
- Driven by a start/done handshake.

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Start/done operand and result bundle for serial_adder.
// master drives the request side, slave is the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock through a registered carry,
// with the result shifted in from the top and published once on completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  if ((DIGIT == 0) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: DIGIT must be nonzero and divide WIDTH, WIDTH >= 2");
  end

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   dig_full;
  logic [WIDTH-1:0] res_shift;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    msb_a_d   = msb_a_q;
    msb_b_d   = msb_b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    dig_full  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    res_shift = (res_q >> DIGIT) | (WIDTH'(dig_full[DIGIT-1:0]) << (WIDTH - DIGIT));

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          msb_a_d = bus.a[WIDTH-1];
          msb_b_d = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = res_shift;
        carry_d = dig_full[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = res_shift;
          cout_d  = dig_full[DIGIT];
          // Operand MSBs were latched at capture since the shifters drop them
          ovf_d   = (msb_a_q == msb_b_q) && (res_shift[WIDTH-1] != msb_a_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule
